multi_rate_divider: RTL and testbench
=====================================

// Module: multi_rate_divider
// PURPOSE
//  Multi-channel programmable rate divider for the DE1 CLOCK_50 domain. Each channel counts
//  enabled clocks against its own runtime-programmable terminal value and emits a 1-cycle tick
//  plus a 50%-ish blink toggle. Sits between the board clock and LED/game-timing logic,
//  replacing single fixed-rate dividers. Rate changes apply glitch-free at the next wrap.
// PARAMETERS
//  NUM_CH        4                      number of independent channels (1..16)
//  CNT_W         28                     counter/rate width; max period 2^CNT_W-1 cycles
//  DEFAULT_RATE  28'd50_000_000         active and shadow rate of every channel after reset (1 Hz)
// PORTS
//  clock      in   1                    system clock (CLOCK_50)
//  reset_n    in   1                    asynchronous, active-low reset
//  enable     in   NUM_CH               per-channel count enable
//  wr_en      in   1                    rate write strobe, 1 cycle
//  wr_ch      in   $clog2(NUM_CH) (min 1)  target channel of write
//  wr_rate    in   CNT_W                new period in clock cycles; 0 = channel stopped
//  tick       out  NUM_CH               registered 1-cycle pulse per period
//  blink      out  NUM_CH               registered; toggles on every tick
//  busy       out  NUM_CH               1 while a written rate is pending (not yet active)
//  sync_clr   in   1                    [RATE_DIV_SYNC_EN only] restart all channels
// BEHAVIOUR
//  Reset (async assert, sync-release use): cnt=0, active=shadow=DEFAULT_RATE, tick=0, blink=0, busy=0.
//  Per channel, each posedge with enable=1 and active!=0:
//   - cnt==active-1: cnt<=0, tick<=1, blink<=~blink; if busy, active<=shadow, busy<=0.
//   - else cnt<=cnt+1, tick<=0. Compare is on CNT_W bits; active-1 never underflows (active!=0).
//  Period = active cycles; active=1 -> tick every enabled cycle, blink toggles every cycle.
//  enable=0: cnt and blink hold, tick<=0; pending rate held until a wrap or stopped state.
//  active==0 (stopped): cnt<=0, tick<=0, blink holds; pending shadow loaded next edge.
//  Write (wr_en=1, wr_ch<NUM_CH): shadow[wr_ch]<=wr_rate, busy<=1 next cycle.
//   - wr_ch>=NUM_CH: write ignored, no state change.
//   - Write on same edge as that channel's wrap: the old shadow is committed to active;
//     new value lands in shadow with busy=1 (applies at the following wrap).
//   - Back-to-back writes to one channel: last write wins, only one pending value.
//   - Write of 0: channel stops at its next wrap (counter parks at 0).
//  Latency: tick/blink change in the cycle after the edge at which cnt==active-1.
//  First tick after reset with enable held 1: visible after DEFAULT_RATE edges.
//  Reset mid-period: all state returns to reset values immediately; pending writes discarded.
// CONFIGURATION
//  RATE_DIV_SYNC_EN defined: sync_clr port exists; sync_clr=1 on an edge forces all cnt<=0,
//   tick<=0, blink<=0 and commits pending shadow to active (busy<=0); overrides wrap on same
//   edge; a write on the same edge still lands in shadow (busy=1). Channels then run phase-aligned.
//  Not defined: no sync_clr port; channels free-run from reset only.
// STRUCTURE
//  Package rate_div_pkg: CNT_W default, DEFAULT_RATE constant, chan_state_t struct
//   {cnt, active, shadow, busy, blink}.
//  Sub-module rate_div_channel: one channel's counter, shadow/active pair and tick/blink regs;
//   top instantiates NUM_CH via generate and decodes wr_en/wr_ch into per-channel write strobes.
// TESTING
//  1. NUM_CH=4, rate ch0=4 via write, enable=4'b0001 -> ch0 tick every 4 cycles, blink period 8; ch1-3 tick=0.
//  2. ch0 rate=1 -> tick held 1 continuously, blink toggles every cycle.
//  3. ch1 running rate=10, write 3 at cnt=5 -> busy=1, next tick after 4 more cycles, then period 3, busy=0.
//  4. Write coincident with wrap (ch2 rate=5, write 2 on cnt==4 edge) -> next period still 5, then 2.
//  5. Write rate=0 to ch3, wr_ch=7 (NUM_CH=4) ignored; ch3 stops after wrap, blink frozen, tick=0.
//  6. reset_n pulsed low mid-period -> outputs 0 same cycle, active=DEFAULT_RATE; with
//     RATE_DIV_SYNC_EN, sync_clr at arbitrary phases -> all channels' ticks aligned afterwards.

Source files
------------

// File: rtl/rate_div_pkg.sv
// Shared constants and per-channel state type for the multi-rate divider.
// Channel state is held in a fixed-width container; CNT_W of the divider must not exceed RATE_DIV_CNT_W.
package rate_div_pkg;

  localparam int RATE_DIV_CNT_W = 28;
  localparam logic [RATE_DIV_CNT_W-1:0] RATE_DIV_DEFAULT_RATE = 28'd50_000_000;

  typedef struct packed {
    logic [RATE_DIV_CNT_W-1:0] cnt;
    logic [RATE_DIV_CNT_W-1:0] active;
    logic [RATE_DIV_CNT_W-1:0] shadow;
    logic                      busy;
    logic                      blink;
  } chan_state_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int rate_div_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rate_div_channel.sv
// One divider channel: counter, shadow/active rate pair, registered tick and blink.
// Optional RATE_DIV_SYNC_EN adds sync_clr, which restarts the channel and commits a pending rate.
module rate_div_channel
  import rate_div_pkg::*;
#(
  parameter int                 CNT_W        = RATE_DIV_CNT_W,
  parameter logic [CNT_W-1:0]   DEFAULT_RATE = CNT_W'(RATE_DIV_DEFAULT_RATE)
)(
  input  logic             clock,
  input  logic             reset_n,
`ifdef RATE_DIV_SYNC_EN
  input  logic             sync_clr,
`endif
  input  logic             enable,
  input  logic             wr_stb,
  input  logic [CNT_W-1:0] wr_rate,
  output logic             tick,
  output logic             blink,
  output logic             busy
);

  localparam int SW = RATE_DIV_CNT_W;
  localparam logic [SW-1:0] ONE      = SW'(1);
  localparam logic [SW-1:0] RST_RATE = SW'(DEFAULT_RATE);

  chan_state_t     st_q;
  chan_state_t     st_d;
  logic            tick_q;
  logic            tick_d;
  logic            clr;
  logic [SW-1:0]   rate_ext;

`ifdef RATE_DIV_SYNC_EN
  assign clr = sync_clr;
`else
  assign clr = 1'b0;
`endif

  assign rate_ext = SW'(wr_rate);

  // Restart beats stopped-state handling beats counting; a write always lands last so
  // a value written on a commit edge stays pending for the next one.
  always_comb begin
    st_d   = st_q;
    tick_d = 1'b0;
    if (clr) begin
      st_d.cnt   = '0;
      st_d.blink = 1'b0;
      if (st_q.busy) begin
        st_d.active = st_q.shadow;
        st_d.busy   = 1'b0;
      end
    end else if (st_q.active == '0) begin
      st_d.cnt = '0;
      if (st_q.busy) begin
        st_d.active = st_q.shadow;
        st_d.busy   = 1'b0;
      end
    end else if (enable) begin
      if (st_q.cnt == st_q.active - ONE) begin
        st_d.cnt   = '0;
        st_d.blink = ~st_q.blink;
        tick_d     = 1'b1;
        if (st_q.busy) begin
          st_d.active = st_q.shadow;
          st_d.busy   = 1'b0;
        end
      end else begin
        st_d.cnt = st_q.cnt + ONE;
      end
    end
    if (wr_stb) begin
      st_d.shadow = rate_ext;
      st_d.busy   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= '{cnt: '0, active: RST_RATE, shadow: RST_RATE, busy: 1'b0, blink: 1'b0};
      tick_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      tick_q <= tick_d;
    end
  end

  assign tick  = tick_q;
  assign blink = st_q.blink;
  assign busy  = st_q.busy;

endmodule

// File: rtl/multi_rate_divider.sv
// Multi-channel programmable rate divider: decodes rate writes onto NUM_CH independent channels.
// Optional RATE_DIV_SYNC_EN adds the sync_clr port that phase-aligns all channels.
module multi_rate_divider
  import rate_div_pkg::*;
#(
  parameter int               NUM_CH       = 4,
  parameter int               CNT_W        = RATE_DIV_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_RATE = CNT_W'(RATE_DIV_DEFAULT_RATE),
  localparam int              CH_W         = rate_div_ch_w(NUM_CH)
)(
  input  logic              clock,
  input  logic              reset_n,
`ifdef RATE_DIV_SYNC_EN
  input  logic              sync_clr,
`endif
  input  logic [NUM_CH-1:0] enable,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_rate,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] blink,
  output logic [NUM_CH-1:0] busy
);

  // A select that matches no channel (wr_ch >= NUM_CH) simply strobes nothing.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_stb;

    assign wr_stb = wr_en && (wr_ch == CH_W'(i));

    rate_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_RATE (DEFAULT_RATE)
    ) u_ch (
      .clock    (clock),
      .reset_n  (reset_n),
`ifdef RATE_DIV_SYNC_EN
      .sync_clr (sync_clr),
`endif
      .enable   (enable[i]),
      .wr_stb   (wr_stb),
      .wr_rate  (wr_rate),
      .tick     (tick[i]),
      .blink    (blink[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Directed bench for multi_rate_divider: expected tick edges are queued by the stimulus
// and consumed by a negedge monitor; blink/busy are checked at hand-computed cycles.
module tb_multi_rate_divider;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        sync_clr = 1'b0;
  logic [3:0]  enable = '0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = '0;
  logic [27:0] wr_rate = '0;
  logic [3:0]  tick, blink, busy;

  logic [2:0]  enable3 = '0;
  logic [1:0]  wr_ch3 = 2'd3;
  logic [2:0]  tick3, blink3, busy3;

  logic [31:0] cyc = '0;
  logic [31:0] c0 = '0;
  int          checks = 0;
  int          errors = 0;
  logic [39:0] exp_q[$];

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  multi_rate_divider #(.NUM_CH(4), .CNT_W(28), .DEFAULT_RATE(28'd6)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
`ifdef RATE_DIV_SYNC_EN
    .sync_clr (sync_clr),
`endif
    .enable   (enable),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_rate  (wr_rate),
    .tick     (tick),
    .blink    (blink),
    .busy     (busy)
  );

  // Three-channel instance: select value 3 is out of range and must be ignored.
  multi_rate_divider #(.NUM_CH(3), .CNT_W(28), .DEFAULT_RATE(28'd6)) dut3 (
    .clock    (clock),
    .reset_n  (reset_n),
`ifdef RATE_DIV_SYNC_EN
    .sync_clr (sync_clr),
`endif
    .enable   (enable3),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch3),
    .wr_rate  (wr_rate),
    .tick     (tick3),
    .blink    (blink3),
    .busy     (busy3)
  );

  // driver tasks
  task automatic goto(input int k);
    while (cyc < c0 + 32'(k)) @(negedge clock);
  endtask

  task automatic wr(input int ch, input int rate);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_rate = 28'(rate);
  endtask

  task automatic push(input int ch, input int k);
    exp_q.push_back({8'(ch), c0 + 32'(k)});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [39:0] item;
    while (exp_q.size() > 0 && exp_q[0][31:0] < cyc) begin
      item = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL tick_missing ch=%0d expected_edge=%0d now=%0d", item[39:32], item[31:0], cyc);
    end
    for (int ch = 0; ch < 4; ch++) begin
      if (tick[ch]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tick_unexpected ch=%0d edge=%0d expected=none", ch, cyc);
        end else begin
          item = exp_q.pop_front();
          if (item !== {8'(ch), cyc}) begin
            errors++;
            $display("FAIL tick_order got ch=%0d edge=%0d expected ch=%0d edge=%0d",
                     ch, cyc, item[39:32], item[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check("reset_tick", 32'(tick), 32'h0);
    check("reset_blink", 32'(blink), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    c0 = cyc;

    // ch0: default rate, then 4, then 1
    reset_n = 1'b1;
    enable  = 4'b0001;
    enable3 = 3'b111;
    push(0, 6); push(0, 10); push(0, 14); push(0, 18);
    for (int k = 19; k <= 26; k++) push(0, k);
    goto(2);  wr(0, 4);
    goto(3);  wr_en = 1'b0;
    check("a_busy_set", 32'(busy), 32'h1);
    check("a_busy3_ignored", 32'(busy3), 32'h0);
    goto(5);  check("a_busy_held", 32'(busy), 32'h1);
    goto(6);  check("a_busy_clr", 32'(busy), 32'h0);
    check("a_blink_1st", 32'(blink), 32'h1);
    check("a_tick3", 32'(tick3), 32'h7);
    check("a_blink3", 32'(blink3), 32'h7);
    goto(7);  check("a_tick3_low", 32'(tick3), 32'h0);
    goto(12); check("a_tick3_period6", 32'(tick3), 32'h7);
    goto(13); check("a_blink_low", 32'(blink), 32'h0);
    goto(14); check("a_blink_high", 32'(blink), 32'h1);
    goto(15); wr(0, 1);
    goto(16); wr_en = 1'b0;
    check("b_busy_set", 32'(busy), 32'h1);
    goto(18); check("b_busy_clr", 32'(busy), 32'h0);
    check("b_blink18", 32'(blink), 32'h0);
    goto(21); check("b_blink21", 32'(blink), 32'h1);
    goto(22); check("b_blink22", 32'(blink), 32'h0);
    goto(26); enable = 4'b0000;
    goto(30); check("b_blink_hold", 32'(blink), 32'h0);

    // ch1: rate 10, rewritten to 3 mid-period
    enable = 4'b0010;
    wr(1, 10);
    push(1, 36); push(1, 46); push(1, 49); push(1, 52); push(1, 55);
    goto(31); wr_en = 1'b0;
    goto(41); wr(1, 3);
    goto(42); wr_en = 1'b0;
    check("c_busy_set", 32'(busy), 32'h2);
    goto(46); check("c_busy_clr", 32'(busy), 32'h0);
    goto(55); enable = 4'b0000;

    // ch2: back-to-back writes, then write coincident with wrap
    goto(60); enable = 4'b0100;
    wr(2, 9);
    push(2, 66); push(2, 71); push(2, 76); push(2, 78); push(2, 80); push(2, 82);
    goto(61); wr(2, 5);
    goto(62); wr_en = 1'b0;
    check("d_busy_b2b", 32'(busy), 32'h4);
    goto(66); check("d_busy_clr", 32'(busy), 32'h0);
    goto(70); wr(2, 2);
    goto(71); wr_en = 1'b0;
    check("d_busy_on_wrap", 32'(busy), 32'h4);
    goto(75); check("d_busy_held", 32'(busy), 32'h4);
    goto(76); check("d_busy_clr2", 32'(busy), 32'h0);
    goto(82); enable = 4'b0000;

    // ch3: rate 0 stops the channel, then restart from stopped state
    goto(90); enable = 4'b1000;
    wr(3, 0);
    push(3, 96);
    goto(91); wr_en = 1'b0;
    goto(96); check("e_blink_after_wrap", 32'(blink), 32'ha);
    goto(102);
    check("e_stopped_busy", 32'(busy), 32'h0);
    check("e_stopped_blink", 32'(blink), 32'ha);
    wr(3, 3);
    push(3, 107); push(3, 110);
    goto(103); wr_en = 1'b0;
    check("e_busy_set", 32'(busy), 32'h8);
    goto(104); check("e_busy_loaded", 32'(busy), 32'h0);
    goto(110); enable = 4'b0000;
    check("e_blink_end", 32'(blink), 32'ha);

    // asynchronous reset mid-operation with a write pending
    goto(115); wr(0, 2);
    goto(116); wr_en = 1'b0;
    check("f_busy_pending", 32'(busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("f_reset_tick", 32'(tick), 32'h0);
    check("f_reset_blink", 32'(blink), 32'h0);
    check("f_reset_busy", 32'(busy), 32'h0);
    goto(118);
    reset_n = 1'b1;
    enable  = 4'b0001;
    push(0, 124);
`ifdef RATE_DIV_SYNC_EN
    goto(124); check("f_busy_after_reset", 32'(busy), 32'h0);
    goto(126); enable = 4'b1111;
    wr(2, 4);
    push(2, 133); push(0, 135); push(1, 135); push(3, 135); push(2, 137);
    push(0, 141); push(1, 141); push(2, 141); push(3, 141);
    goto(127); wr_en = 1'b0;
    goto(128); check("g_busy_pre", 32'(busy), 32'h4);
    check("g_blink_pre", 32'(blink), 32'h1);
    sync_clr = 1'b1;
    goto(129); sync_clr = 1'b0;
    check("g_blink_clr", 32'(blink), 32'h0);
    check("g_busy_commit", 32'(busy), 32'h0);
    goto(141); enable = 4'b0000;
`else
    push(0, 130);
    goto(124); check("f_busy_after_reset", 32'(busy), 32'h0);
    goto(130); enable = 4'b0000;
`endif

    goto(150);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
